// File: rtl/input_mems_db_pkg.sv
// Shared types and width helpers for the double-buffered matrix input store.
package input_mems_db_pkg;

  // Width used for size/limit arithmetic so M*K and K*N never truncate.
  localparam int unsigned CMP_W = 32;

  typedef enum logic [1:0] {
    W_FIRST = 2'd0,
    W_A     = 2'd1,
    W_B     = 2'd2,
    W_WAIT  = 2'd3
  } w_state_t;

endpackage

// File: rtl/input_mems_db_dp_memory.sv
// Simple dual-port RAM: independent write port, registered read port.
module dp_memory #(
  parameter int unsigned W  = 12,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/input_mems_db.sv
// Multi-slot A/B matrix input store fed by an AXI-stream; one slot fills while
// another is read. Optional feature: INPUT_MEMS_DB_KEEPA_EN lets a load reuse
// the most recently loaded A matrix (newA=0 loads write B only).
module input_mems_db
  import input_mems_db_pkg::*;
#(
  parameter int INW   = 12,
  parameter int M     = 7,
  parameter int N     = 9,
  parameter int MAXK  = 8,
  parameter int NSLOT = 2,
  localparam int unsigned K_BITS      = $clog2(MAXK + 1),
  localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK),
  localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N),
  localparam int unsigned S_BITS      = $clog2(NSLOT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INW-1:0]           AXIS_TDATA,
  input  logic                     AXIS_TVALID,
  input  logic [K_BITS:0]          AXIS_TUSER,
  output logic                     AXIS_TREADY,
  output logic                     matrices_loaded,
  input  logic                     compute_finished,
  output logic [K_BITS-1:0]        K,
  input  logic [A_ADDR_BITS-1:0]   A_read_addr,
  output logic signed [INW-1:0]    A_data,
  input  logic [B_ADDR_BITS-1:0]   B_read_addr,
  output logic signed [INW-1:0]    B_data
);

  w_state_t state, state_next;

  logic [S_BITS-1:0]      ws, rs, ws_inc, a_src;
  logic [NSLOT-1:0]       full;
  logic [K_BITS-1:0]      kslot [NSLOT];
  logic [S_BITS-1:0]      aslot [NSLOT];
  logic [A_ADDR_BITS-1:0] a_cnt, a_cnt_next, a_waddr;
  logic [B_ADDR_BITS-1:0] b_cnt, b_cnt_next, b_waddr;

  logic              beat, a_we, b_we, k_latch, done;
  logic              release_rs, next_empty, use_a, k_ok;
  logic [K_BITS-1:0] beat_k;
  logic [CMP_W-1:0]  k_cur, a_last, b_last;
  logic [INW-1:0]    a_rdata, b_rdata;

  assign beat_k = AXIS_TUSER[K_BITS:1];
  assign k_ok   = (beat_k != '0) && (CMP_W'(beat_k) <= CMP_W'(MAXK));
  assign k_cur  = (state == W_FIRST) ? CMP_W'(beat_k) : CMP_W'(kslot[ws]);
  assign a_last = CMP_W'(M) * k_cur - CMP_W'(1);
  assign b_last = k_cur * CMP_W'(N) - CMP_W'(1);

  assign ws_inc     = ws + S_BITS'(1);
  assign release_rs = compute_finished && full[rs];
  assign next_empty = !full[ws_inc] || (release_rs && (rs == ws_inc));

`ifdef INPUT_MEMS_DB_KEEPA_EN
  logic [S_BITS-1:0] last_a;
  logic              a_busy;

  assign use_a = AXIS_TUSER[0];
  assign a_src = use_a ? ws : last_a;

  // A region of the write slot is still referenced by some full slot
  always_comb begin
    a_busy = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (full[s] && (aslot[s] == ws)) a_busy = 1'b1;
    end
  end

  // Remember which A region was loaded most recently
  always_ff @(posedge clk) begin
    if (reset) last_a <= '0;
    else if (k_latch && use_a) last_a <= ws;
  end
`else
  logic unused_newa;
  assign unused_newa = AXIS_TUSER[0];
  assign use_a       = 1'b1;
  assign a_src       = ws;
`endif

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= W_FIRST;
    else       state <= state_next;
  end

  // Write FSM next state, handshake and write-port controls
  always_comb begin
    state_next  = state;
    AXIS_TREADY = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    a_waddr     = a_cnt;
    b_waddr     = b_cnt;
    a_cnt_next  = a_cnt;
    b_cnt_next  = b_cnt;
    k_latch     = 1'b0;
    done        = 1'b0;

    if (!reset) AXIS_TREADY = (state != W_WAIT);
`ifdef INPUT_MEMS_DB_KEEPA_EN
    if ((state == W_FIRST) && use_a && a_busy) AXIS_TREADY = 1'b0;
`endif
    beat = AXIS_TVALID && AXIS_TREADY;

    case (state)
      W_FIRST: begin
        if (beat && k_ok) begin
          k_latch = 1'b1;
          if (use_a) begin
            a_we    = 1'b1;
            a_waddr = '0;
            if (a_last == '0) begin
              state_next = W_B;
              b_cnt_next = '0;
            end else begin
              state_next = W_A;
              a_cnt_next = A_ADDR_BITS'(1);
            end
          end else begin
            b_we    = 1'b1;
            b_waddr = '0;
            if (b_last == '0) done = 1'b1;
            else begin
              state_next = W_B;
              b_cnt_next = B_ADDR_BITS'(1);
            end
          end
        end
      end
      W_A: begin
        if (beat) begin
          a_we = 1'b1;
          if (CMP_W'(a_cnt) == a_last) begin
            state_next = W_B;
            a_cnt_next = '0;
            b_cnt_next = '0;
          end else begin
            a_cnt_next = a_cnt + A_ADDR_BITS'(1);
          end
        end
      end
      W_B: begin
        if (beat) begin
          b_we = 1'b1;
          if (CMP_W'(b_cnt) == b_last) done = 1'b1;
          else b_cnt_next = b_cnt + B_ADDR_BITS'(1);
        end
      end
      W_WAIT: begin
        if (!full[ws]) state_next = W_FIRST;
      end
      default: state_next = W_FIRST;
    endcase

    if (done) begin
      state_next = next_empty ? W_FIRST : W_WAIT;
      a_cnt_next = '0;
      b_cnt_next = '0;
    end
  end

  // Slot bookkeeping: write/read pointers, full flags, per-slot K and A region
  always_ff @(posedge clk) begin
    if (reset) begin
      ws    <= '0;
      rs    <= '0;
      full  <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
      for (int s = 0; s < NSLOT; s++) begin
        kslot[s] <= '0;
        aslot[s] <= '0;
      end
    end else begin
      a_cnt <= a_cnt_next;
      b_cnt <= b_cnt_next;
      if (k_latch) begin
        kslot[ws] <= beat_k;
        aslot[ws] <= a_src;
      end
      if (release_rs) begin
        full[rs] <= 1'b0;
        rs       <= rs + S_BITS'(1);
      end
      if (done) begin
        full[ws] <= 1'b1;
        ws       <= ws_inc;
      end
    end
  end

  assign matrices_loaded = full[rs];
  assign K               = full[rs] ? kslot[rs] : '0;

  dp_memory #(.W(INW), .AW(S_BITS + A_ADDR_BITS)) u_a_mem (
    .clk   (clk),
    .we    (a_we),
    .waddr ({ws, a_waddr}),
    .wdata (AXIS_TDATA),
    .raddr ({aslot[rs], A_read_addr}),
    .rdata (a_rdata)
  );

  dp_memory #(.W(INW), .AW(S_BITS + B_ADDR_BITS)) u_b_mem (
    .clk   (clk),
    .we    (b_we),
    .waddr ({ws, b_waddr}),
    .wdata (AXIS_TDATA),
    .raddr ({rs, B_read_addr}),
    .rdata (b_rdata)
  );

  assign A_data = a_rdata;
  assign B_data = b_rdata;

endmodule

// File: tb/tb_input_mems_db.sv
// Directed bench for input_mems_db (default parameters, two slots).
module tb_input_mems_db;

  localparam int M_P = 7;
  localparam int N_P = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] AXIS_TDATA;
  logic        AXIS_TVALID;
  logic [4:0]  AXIS_TUSER;
  logic        AXIS_TREADY;
  logic        matrices_loaded;
  logic        compute_finished;
  logic [3:0]  K;
  logic [5:0]  A_read_addr;
  logic signed [11:0] A_data;
  logic [6:0]  B_read_addr;
  logic signed [11:0] B_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of slot contents
  logic [11:0] ma [2][64];
  logic [11:0] mb [2][128];
  bit          aref [2];
  bit          last_a, b_ws, b_rs;

  string       tag_q[$];
  logic [31:0] val_q[$];

  input_mems_db dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
    .AXIS_TREADY      (AXIS_TREADY),
    .matrices_loaded  (matrices_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .A_read_addr      (A_read_addr),
    .A_data           (A_data),
    .B_read_addr      (B_read_addr),
    .B_data           (B_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [11:0] d, input logic na, input logic [3:0] k);
    int waitc;
    waitc = 0;
    AXIS_TDATA  = d;
    AXIS_TUSER  = {k, na};
    AXIS_TVALID = 1'b1;
    #1;
    while (!AXIS_TREADY && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!AXIS_TREADY) chk("tready_timeout", 32'(AXIS_TREADY), 32'(1));
    @(posedge clk); #1;
    AXIS_TVALID = 1'b0;
  endtask

  task automatic load(input int k, input logic na, input int base, input logic cf_last);
    logic        use_a;
    int          nab, nbb;
    logic [11:0] d;
`ifdef INPUT_MEMS_DB_KEEPA_EN
    use_a = na;
`else
    use_a = 1'b1;
`endif
    nab = use_a ? M_P * k : 0;
    nbb = k * N_P;
    for (int i = 0; i < nab; i++) begin
      d = 12'(base + i);
      ma[b_ws][i] = d;
      send_beat(d, na, 4'(k));
    end
    for (int i = 0; i < nbb; i++) begin
      d = 12'(base + 200 + i);
      mb[b_ws][i] = d;
      if (cf_last && (i == nbb - 1)) compute_finished = 1'b1;
      send_beat(d, na, 4'(k));
      compute_finished = 1'b0;
    end
    if (use_a) begin
      aref[b_ws] = b_ws;
      last_a     = b_ws;
    end else begin
      aref[b_ws] = last_a;
    end
    b_ws = ~b_ws;
    if (cf_last) b_rs = ~b_rs;
  endtask

  task automatic pulse_cf();
    compute_finished = 1'b1;
    @(posedge clk); #1;
    compute_finished = 1'b0;
    b_rs = ~b_rs;
  endtask

  // Present read addresses, queue expected data, compare when the data appears
  task automatic rd_check(input string tag, input int a, input int b);
    A_read_addr = 6'(a);
    B_read_addr = 7'(b);
    tag_q.push_back({tag, "_A"});
    val_q.push_back({20'b0, ma[aref[b_rs]][a]});
    tag_q.push_back({tag, "_B"});
    val_q.push_back({20'b0, mb[b_rs][b]});
    @(posedge clk); #1;
    chk(tag_q.pop_front(), {20'b0, A_data}, val_q.pop_front());
    chk(tag_q.pop_front(), {20'b0, B_data}, val_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("tready_in_reset", 32'(AXIS_TREADY), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    b_ws = 1'b0; b_rs = 1'b0; last_a = 1'b0;
    aref[0] = 1'b0; aref[1] = 1'b1;
    #1;
    chk("post_reset_tready", 32'(AXIS_TREADY), 32'(1));
    chk("post_reset_loaded", 32'(matrices_loaded), 32'(0));
    chk("post_reset_k", 32'(K), 32'(0));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; AXIS_TDATA = '0; AXIS_TVALID = 1'b0; AXIS_TUSER = '0;
    compute_finished = 1'b0; A_read_addr = '0; B_read_addr = '0;
    @(posedge clk); #1;
    do_reset();

    // K=2 load into slot 0
    load(2, 1'b1, 'h010, 1'b0);
    chk("t1_loaded", 32'(matrices_loaded), 32'(1));
    chk("t1_k", 32'(K), 32'(2));
    rd_check("t1_rd5", 5, 17);
    rd_check("t1_rd0", 0, 0);

    // Second load fills slot 1; third load must stall
    load(3, 1'b1, 'h800, 1'b0);
    chk("t2_wait_tready", 32'(AXIS_TREADY), 32'(0));
    chk("t2_k_still0", 32'(K), 32'(2));
    AXIS_TVALID = 1'b1; AXIS_TUSER = {4'd1, 1'b1}; AXIS_TDATA = 'h300;
    #1;
    chk("t2_third_first_beat", 32'(AXIS_TREADY), 32'(0));
    @(posedge clk); #1;
    chk("t2_third_still_wait", 32'(AXIS_TREADY), 32'(0));
    AXIS_TVALID = 1'b0;
    pulse_cf();
    chk("t2_rel_loaded", 32'(matrices_loaded), 32'(1));
    chk("t2_rel_k", 32'(K), 32'(3));
    cnt = 0;
    while (!AXIS_TREADY && cnt < 4) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("t2_tready_after_rel", 32'(AXIS_TREADY), 32'(1));
    chk("t2_rel_latency", 32'(cnt), 32'(1));
    rd_check("t2_rd_slot1", 20, 26);

    // Slot 0 reload, then slot 1 completes in the same cycle slot 0 is released
    load(1, 1'b1, 'h300, 1'b0);
    chk("t3_k_slot1", 32'(K), 32'(3));
    pulse_cf();
    chk("t3_k_slot0", 32'(K), 32'(1));
    rd_check("t3_rd_slot0", 6, 8);
    load(4, 1'b1, 'h400, 1'b1);
    chk("t3_no_gap_loaded", 32'(matrices_loaded), 32'(1));
    chk("t3_no_gap_k", 32'(K), 32'(4));
    chk("t3_tready", 32'(AXIS_TREADY), 32'(1));
    rd_check("t3_rd_slot1", 27, 35);
    pulse_cf();
    chk("t3_empty_loaded", 32'(matrices_loaded), 32'(0));
    chk("t3_empty_k", 32'(K), 32'(0));

    // Illegal K values are discarded
    send_beat('h123, 1'b1, 4'd0);
    chk("t4_k0_tready", 32'(AXIS_TREADY), 32'(1));
    chk("t4_k0_loaded", 32'(matrices_loaded), 32'(0));
    send_beat('h124, 1'b1, 4'd9);
    chk("t4_k9_loaded", 32'(matrices_loaded), 32'(0));
    load(3, 1'b1, 'h500, 1'b0);
    chk("t4_loaded", 32'(matrices_loaded), 32'(1));
    chk("t4_k", 32'(K), 32'(3));
    rd_check("t4_rd_first", 0, 0);
    rd_check("t4_rd_last", 20, 26);

    // Reset mid-load, then a fresh K=1 load
    for (int i = 0; i < 5; i++) send_beat(12'('h050 + i), 1'b1, 4'd2);
    do_reset();
    load(1, 1'b1, 'h600, 1'b0);
    chk("t5_loaded", 32'(matrices_loaded), 32'(1));
    chk("t5_k", 32'(K), 32'(1));
    rd_check("t5_rd", 3, 8);

`ifdef INPUT_MEMS_DB_KEEPA_EN
    // B-only load reuses slot 0's A matrix
    do_reset();
    load(2, 1'b1, 'h700, 1'b0);
    load(2, 1'b0, 'h050, 1'b0);
    pulse_cf();
    chk("t6_loaded", 32'(matrices_loaded), 32'(1));
    chk("t6_k", 32'(K), 32'(2));
    rd_check("t6_rd_shared_a", 5, 17);
    @(posedge clk); #1;
    AXIS_TVALID = 1'b1; AXIS_TUSER = {4'd2, 1'b1};
    #1;
    chk("t6_a_locked", 32'(AXIS_TREADY), 32'(0));
    AXIS_TUSER = {4'd2, 1'b0};
    #1;
    chk("t6_b_only_ok", 32'(AXIS_TREADY), 32'(1));
    AXIS_TVALID = 1'b0; AXIS_TUSER = {4'd2, 1'b1};
    pulse_cf();
    chk("t6_released", 32'(matrices_loaded), 32'(0));
    chk("t6_a_unlocked", 32'(AXIS_TREADY), 32'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
